pwm_gen: RTL and testbench
==========================

Name: pwm_gen

Overview:
Counter-based PWM generator that drives a PWM pin from a signed duty request, with period-aligned double-buffered updates and a load watchdog. It sits directly upstream of the PWM width measurement block, which it drives in loopback tests. Its high-time is exactly `duty` clocks per `period` clocks, so the measured width equals the requested duty magnitude.

Parameters:
- WIDTH, 32: width of period/duty/counter.
- WDT_CNT, 50000000: clocks without a `load` strobe before fault; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  run request; low forces IDLE
- load  in  1  single-cycle strobe: capture `period`/`duty` into the pending registers, kick the watchdog
- period  in  WIDTH  period in clocks (unsigned)
- duty  in  WIDTH  signed duty in clocks; sign selects `dir`
- pwm  out  1  registered PWM output
- dir  out  1  registered direction, 1 = negative duty
- cycle_start  out  1  one-clock pulse at the first clock of each period
- fault  out  1  watchdog expired, sticky until `enable` is low

Behaviour:
- Reset (async) values: pwm=0, dir=0, cycle_start=0, fault=0, state=IDLE, cnt=0, pending/active registers=0, wdt counter=0.
- Pending registers: on `load`=1, capture `period`, `|duty|` and the sign of `duty`.
  - Magnitude of the most negative value (-2^(WIDTH-1)) saturates to 2^(WIDTH-1)-1.
  - `load` is accepted in any state.
- Active registers copy the pending registers only at a period boundary: entry to RUN, or the clock where cnt==per_a-1. No mid-period change, ever.
- Effective duty: mag_a clamped to per_a.
- IDLE:
  - pwm=0, cnt=0, wdt counter=0.
  - enable=1 -> RUN next clock; active registers load from pending in the same clock.
- RUN:
  - cnt counts 0..per_a-1 and wraps to 0.
  - pwm registered = (cnt < mag_a), so it lags cnt by one clock; high for exactly min(mag_a, per_a) consecutive clocks per period.
  - dir follows the active sign.
  - cycle_start=1 in the clock where the registered pwm reflects cnt==0.
- per_a==0: pwm=0, cnt holds 0, cycle_start=0. Pending values are re-checked every clock so a later nonzero period starts immediately.
- mag_a==0: pwm constant low. mag_a>=per_a: pwm constant high; cycle_start still pulses.
- Watchdog:
  - In RUN, the wdt counter increments each clock and clears on `load`.
  - When it reaches WDT_CNT (and WDT_CNT!=0): go to FAULT.
- FAULT:
  - pwm=0 on the next clock; fault=1; cnt=0.
  - Stays in FAULT regardless of `load`.
  - enable=0 -> IDLE, fault cleared in the same transition.
- enable deasserted in RUN: IDLE next clock, pwm=0 immediately (no period completion).
- `load` and a period boundary in the same clock: the new values go to pending this clock and reach active at the following boundary. Exception: the boundary is entry to RUN, in which case `load` data bypasses pending and is used directly.
- Reset mid-period: all outputs drop asynchronously to their reset values.

Decomposition:
- Shared package: state enum (IDLE, RUN, FAULT) and the saturated-magnitude helper function.
- One natural sub-module: `pwm_wdt` (load-kick watchdog counter, parameter WDT_CNT, outputs expire pulse). It is reusable by other output plugins.

Test Plan:
- period=10, duty=3, load, enable -> pwm high 3 clocks / low 7, repeating; cycle_start every 10 clocks; dir=0.
- duty=-4 loaded mid-period (period=10) -> current period keeps duty 3; next period high 4 clocks, dir=1 from that boundary.
- duty=15 with period=10 -> pwm constant high, cycle_start still every 10 clocks. duty=0 -> constant low.
- duty=-2^31, period=2^31+5 -> pwm high 2^31-1 clocks, low 6 clocks (run with WIDTH=32, short sim via forced counters); dir=1.
- WDT_CNT=100, no `load` after start -> fault=1 and pwm=0 at clock 101. `load` ignored while in FAULT. enable low then high -> fault=0, running again.
- Assert rst during the high phase -> pwm, fault and cycle_start go 0 without waiting for a clock; after release, state IDLE.

Source files
------------

// File: rtl/pwm_gen_pkg.sv
// Shared types and helpers for the PWM generator and its output plugins.
// Holds the run-state encoding and the saturating magnitude used on signed duty requests.
package pwm_gen_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FAULT
   } state_t;

   localparam int MAX_W = 64;

   // v is sign-extended to MAX_W; w is the native width. The most negative value clamps to 2^(w-1)-1.
   function automatic logic [MAX_W-1:0] sat_mag(input logic [MAX_W-1:0] v, input int unsigned w);
      logic [MAX_W-1:0] lim;
      logic [MAX_W-1:0] neg;
      lim = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
      neg = ~v + MAX_W'(1);
      if (!v[MAX_W-1]) return v;
      if (neg > lim) return lim;
      return neg;
   endfunction

endpackage

// File: rtl/pwm_gen_if.sv
// Control and output bundle of the PWM generator.
// The master drives run/load/period/duty; the slave (generator) drives the pin-side outputs.
interface pwm_gen_if #(
   parameter int WIDTH = 32
);
   logic             enable;
   logic             load;
   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] duty;
   logic             pwm;
   logic             dir;
   logic             cycle_start;
   logic             fault;

   modport master (
      output enable, load, period, duty,
      input  pwm, dir, cycle_start, fault
   );

   modport slave (
      input  enable, load, period, duty,
      output pwm, dir, cycle_start, fault
   );
endinterface

// File: rtl/pwm_gen_wdt.sv
// Load-kick watchdog: counts run clocks since the last kick and flags expiry at WDT_CNT (0 disables).
// expire is combinational from the count; a kick in the expiring clock wins.
module pwm_wdt #(
   parameter int unsigned WDT_CNT = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic kick,
   output logic expire
);
   localparam int CW = (WDT_CNT < 1) ? 1 : $clog2(WDT_CNT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(WDT_CNT);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!run || kick) begin
         cnt <= '0;
      end else if (cnt != LIMIT) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expire = (WDT_CNT != 0) && run && !kick && (cnt == LIMIT);

endmodule

// File: rtl/pwm_gen.sv
// Counter PWM generator with double-buffered period/duty, sign-to-direction and a load watchdog.
// Outputs are registered one clock behind the period counter; no backpressure, load accepted any clock.
module pwm_gen
   import pwm_gen_pkg::*;
#(
   parameter int          WIDTH   = 32,
   parameter int unsigned WDT_CNT = 50000000
) (
   input logic      clk,
   input logic      rst,
   pwm_gen_if.slave bus
);
   state_t           state, state_n;
   logic [WIDTH-1:0] cnt, cnt_n;
   logic [WIDTH-1:0] per_p, mag_p;
   logic             neg_p;
   logic [WIDTH-1:0] per_a, mag_a, per_a_n, mag_a_n;
   logic             neg_a, neg_a_n;
   logic             pwm_q, pwm_n;
   logic             dir_q, dir_n;
   logic             cs_q, cs_n;
   logic             fault_q, fault_n;

   logic [MAX_W-1:0] duty_sx;
   logic [WIDTH-1:0] load_mag;
   logic [WIDTH-1:0] byp_per, byp_mag;
   logic             byp_neg;
   logic             run_st;
   logic             wdt_expire;

   assign duty_sx  = {{(MAX_W-WIDTH){bus.duty[WIDTH-1]}}, bus.duty};
   assign load_mag = WIDTH'(sat_mag(duty_sx, WIDTH));

   // Pending view including a load in this very clock; used where new data may bypass pending.
   assign byp_per = bus.load ? bus.period        : per_p;
   assign byp_mag = bus.load ? load_mag          : mag_p;
   assign byp_neg = bus.load ? bus.duty[WIDTH-1] : neg_p;

   assign run_st = (state == RUN);

   pwm_wdt #(
      .WDT_CNT(WDT_CNT)
   ) u_wdt (
      .clk    (clk),
      .rst    (rst),
      .run    (run_st),
      .kick   (bus.load),
      .expire (wdt_expire)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      per_a_n = per_a;
      mag_a_n = mag_a;
      neg_a_n = neg_a;
      pwm_n   = 1'b0;
      cs_n    = 1'b0;
      dir_n   = dir_q;
      fault_n = fault_q;
      case (state)
         IDLE: begin
            cnt_n   = '0;
            fault_n = 1'b0;
            if (bus.enable) begin
               state_n = RUN;
               per_a_n = byp_per;
               mag_a_n = byp_mag;
               neg_a_n = byp_neg;
            end
         end
         RUN: begin
            if (!bus.enable) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (wdt_expire) begin
               state_n = FAULT;
               fault_n = 1'b1;
               cnt_n   = '0;
            end else begin
               dir_n = neg_a;
               if (per_a == '0) begin
                  // Zero period parks the counter and keeps polling pending for a usable period.
                  cnt_n   = '0;
                  per_a_n = byp_per;
                  mag_a_n = byp_mag;
                  neg_a_n = byp_neg;
               end else begin
                  pwm_n = (cnt < mag_a);
                  cs_n  = (cnt == '0);
                  if (cnt == per_a - 1'b1) begin
                     cnt_n   = '0;
                     per_a_n = per_p;
                     mag_a_n = mag_p;
                     neg_a_n = neg_p;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end
            end
         end
         FAULT: begin
            cnt_n = '0;
            if (!bus.enable) begin
               state_n = IDLE;
               fault_n = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         per_p   <= '0;
         mag_p   <= '0;
         neg_p   <= 1'b0;
         per_a   <= '0;
         mag_a   <= '0;
         neg_a   <= 1'b0;
         pwm_q   <= 1'b0;
         dir_q   <= 1'b0;
         cs_q    <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         per_a   <= per_a_n;
         mag_a   <= mag_a_n;
         neg_a   <= neg_a_n;
         pwm_q   <= pwm_n;
         dir_q   <= dir_n;
         cs_q    <= cs_n;
         fault_q <= fault_n;
         if (bus.load) begin
            per_p <= bus.period;
            mag_p <= load_mag;
            neg_p <= bus.duty[WIDTH-1];
         end
      end
   end

   assign bus.pwm         = pwm_q;
   assign bus.dir         = dir_q;
   assign bus.cycle_start = cs_q;
   assign bus.fault       = fault_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Scoreboard bench for pwm_gen: a behavioural model predicts every registered output clock by clock.
// A narrow second instance checks the most-negative duty saturation over whole periods.
module tb_pwm_gen;
   localparam int          W   = 32;
   localparam int unsigned WDT = 100;
   localparam int          P8  = 133;

   typedef struct packed {
      logic pwm;
      logic dir;
      logic cs;
      logic fault;
   } exp_t;

   logic clk  = 1'b0;
   logic rst  = 1'b0;
   logic rst8 = 1'b0;
   always #5 clk = ~clk;

   pwm_gen_if #(.WIDTH(W)) bus ();
   pwm_gen_if #(.WIDTH(8)) bus8 ();

   pwm_gen #(.WIDTH(W), .WDT_CNT(WDT)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   pwm_gen #(.WIDTH(8), .WDT_CNT(0)) u_dut8 (
      .clk (clk),
      .rst (rst8),
      .bus (bus8)
   );

   int   n_cmp = 0;
   int   n_err = 0;
   bit   done8 = 1'b0;
   exp_t sb_q[$];

   // Reference model state: mode 0 idle, 1 run, 2 fault; pos = clocks elapsed in current period.
   int     m_mode;
   longint m_pos, m_wdt;
   longint p_per, p_mag, a_per, a_mag;
   bit     p_neg, a_neg;
   exp_t   m_out;

   function automatic longint mag_of(input logic [31:0] d);
      longint sd;
      sd = longint'($signed(d));
      if (sd < 0) sd = -sd;
      if (sd > 64'sd2147483647) sd = 64'sd2147483647;
      return sd;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pos = 0; m_wdt = 0;
      p_per = 0; p_mag = 0; a_per = 0; a_mag = 0;
      p_neg = 1'b0; a_neg = 1'b0;
      m_out = '0;
   endtask

   task automatic model_step(input bit en, input bit ld, input logic [31:0] per, input logic [31:0] d);
      longint n_per, n_mag, eff;
      bit     n_neg;
      n_per = ld ? longint'(per) : p_per;
      n_mag = ld ? mag_of(d) : p_mag;
      n_neg = ld ? d[31] : p_neg;
      m_out.pwm = 1'b0;
      m_out.cs  = 1'b0;
      case (m_mode)
         0: begin
            m_out.fault = 1'b0;
            if (en) begin
               m_mode = 1; m_pos = 0; m_wdt = 0;
               a_per = n_per; a_mag = n_mag; a_neg = n_neg;
            end
         end
         1: begin
            if (!en) begin
               m_mode = 0;
            end else if (WDT != 0 && m_wdt == longint'(WDT) && !ld) begin
               m_mode = 2;
               m_out.fault = 1'b1;
            end else begin
               m_wdt = ld ? 0 : m_wdt + 1;
               m_out.dir = a_neg;
               if (a_per == 0) begin
                  a_per = n_per; a_mag = n_mag; a_neg = n_neg;
               end else begin
                  eff = (a_mag < a_per) ? a_mag : a_per;
                  m_out.pwm = (m_pos < eff);
                  m_out.cs  = (m_pos == 0);
                  m_pos++;
                  if (m_pos == a_per) begin
                     m_pos = 0;
                     a_per = p_per; a_mag = p_mag; a_neg = p_neg;
                  end
               end
            end
         end
         default: begin
            if (!en) begin
               m_mode = 0;
               m_out.fault = 1'b0;
            end
         end
      endcase
      p_per = n_per; p_mag = n_mag; p_neg = n_neg;
      sb_q.push_back(m_out);
   endtask

   task automatic drive(input bit en, input bit ld, input logic [31:0] per, input logic [31:0] d);
      @(negedge clk);
      bus.enable = en;
      bus.load   = ld;
      bus.period = per;
      bus.duty   = d;
      model_step(en, ld, per, d);
   endtask

   task automatic check(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every clock the DUT presents one output sample; pop and compare against the model.
   initial begin : monitor
      exp_t e;
      exp_t a;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = '{bus.pwm, bus.dir, bus.cycle_start, bus.fault};
            n_cmp++;
            if (a !== e) begin
               n_err++;
               $display("FAIL sb pwm/dir/cs/fault: got %b%b%b%b expected %b%b%b%b at %0t",
                        a.pwm, a.dir, a.cs, a.fault, e.pwm, e.dir, e.cs, e.fault, $time);
            end
         end
      end
   end

   // Narrow instance: duty = -2^7 saturates to 127, period 2^7+5 gives 127 high / 6 low.
   initial begin : w8
      int pos;
      bus8.enable = 1'b0; bus8.load = 1'b0; bus8.period = '0; bus8.duty = '0;
      #1 rst8 = 1'b1;
      #11 rst8 = 1'b0;
      @(negedge clk);
      bus8.enable = 1'b1; bus8.load = 1'b1; bus8.period = 8'(P8); bus8.duty = 8'h80;
      @(negedge clk);
      bus8.load = 1'b0;
      for (int j = 1; j <= 3 * P8; j++) begin
         @(negedge clk);
         pos = (j - 1) % P8;
         check("w8_pwm", bus8.pwm, pos < 127);
         check("w8_cycle_start", bus8.cycle_start, pos == 0);
         check("w8_dir", bus8.dir, 1'b1);
      end
      done8 = 1'b1;
   end

   initial begin : limit
      #2000000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin : stim
      bit seen;
      int ld_pct;
      bit en, ld;
      logic [31:0] per, d;
      bus.enable = 1'b0; bus.load = 1'b0; bus.period = '0; bus.duty = '0;
      model_reset();
      #1 rst = 1'b1;
      #1;
      check("rst_pwm", bus.pwm, 1'b0);
      check("rst_dir", bus.dir, 1'b0);
      check("rst_cycle_start", bus.cycle_start, 1'b0);
      check("rst_fault", bus.fault, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Basic 3/10, then -4 loaded mid-period, constant high, constant low, most-negative duty.
      drive(1, 1, 32'd10, 32'd3);
      repeat (29) drive(1, 0, 32'd10, 32'd3);
      repeat (4) drive(1, 0, 32'd10, 32'd3);
      drive(1, 1, 32'd10, 32'hFFFF_FFFC);
      repeat (29) drive(1, 0, 32'd10, 32'd0);
      drive(1, 1, 32'd10, 32'd15);
      repeat (24) drive(1, 0, 32'd10, 32'd0);
      drive(1, 1, 32'd10, 32'd0);
      repeat (20) drive(1, 0, 32'd10, 32'd0);
      drive(1, 1, 32'd10, 32'h8000_0000);
      repeat (20) drive(1, 0, 32'd10, 32'd0);

      // Watchdog: no load after entry, fault must appear exactly 101 clocks later.
      drive(0, 0, 32'd0, 32'd0);
      drive(1, 1, 32'd10, 32'd3);
      for (int k = 1; k <= 102; k++) begin
         drive(1, 0, 32'd10, 32'd3);
         if (k == 101) check("wdt_fault_before", bus.fault, 1'b0);
         if (k == 102) begin
            check("wdt_fault_at_101", bus.fault, 1'b1);
            check("wdt_pwm_low", bus.pwm, 1'b0);
         end
      end
      repeat (3) drive(1, 1, 32'd10, 32'd5);
      drive(1, 0, 32'd10, 32'd5);
      check("fault_sticky_on_load", bus.fault, 1'b1);
      drive(0, 0, 32'd10, 32'd5);
      drive(1, 1, 32'd10, 32'd3);
      check("fault_cleared", bus.fault, 1'b0);
      repeat (15) drive(1, 0, 32'd10, 32'd3);

      // Async reset during the high phase.
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         drive(1, 0, 32'd10, 32'd3);
         seen = bus.cycle_start;
      end
      if (!seen) begin
         n_cmp++; n_err++;
         $display("FAIL wait_cycle_start: got no pulse expected pulse within 30 clocks");
      end
      @(posedge clk);
      #2;
      check("pre_rst_pwm_high", bus.pwm, 1'b1);
      bus.enable = 1'b0; bus.load = 1'b0;
      rst = 1'b1;
      #1;
      check("async_rst_pwm", bus.pwm, 1'b0);
      check("async_rst_fault", bus.fault, 1'b0);
      check("async_rst_cycle_start", bus.cycle_start, 1'b0);
      sb_q.delete();
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) drive(0, 0, 32'd0, 32'd0);
      repeat (3) drive(1, 0, 32'd0, 32'd0);
      drive(1, 1, 32'd7, 32'hFFFF_FFFE);
      repeat (20) drive(1, 0, 32'd0, 32'd0);

      // Randomised traffic; some segments load rarely so the watchdog trips.
      ld_pct = 12;
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 0) ld_pct = ($urandom_range(0, 2) == 0) ? 1 : 12;
         en  = ($urandom_range(0, 99) < 97);
         ld  = ($urandom_range(0, 99) < ld_pct);
         per = 32'($urandom_range(0, 12));
         case ($urandom_range(0, 19))
            0:       d = 32'h8000_0000;
            1:       d = 32'h7FFF_FFFF;
            default: d = 32'(int'($urandom_range(0, 30)) - 15);
         endcase
         drive(en, ld, per, d);
      end
      drive(0, 0, 32'd0, 32'd0);
      @(posedge clk);
      #2;

      for (int k = 0; k < 1000 && !done8; k++) @(negedge clk);
      if (!done8) begin
         n_cmp++; n_err++;
         $display("FAIL w8_done: got unfinished expected finished");
      end
      if (sb_q.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL sb_drain: got %0d entries expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
